// File: rtl/uart_rx_cmd.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cmd
// Purpose  : 8N1 UART receiver feeding a register-write command parser
//            (0x55, addr, data[31:0] MSB first). Define UART_RX_CKSUM_EN to
//            append and check an XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cmd #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BUAD_RATE  = 115200,
    parameter int TIMEOUT_MS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic [7:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    output logic        cmd_err
);

    localparam logic [15:0] c_BAUD_DIV    = 16'(CLK_FREQ / BUAD_RATE);
    localparam logic [15:0] c_HALF_DIV    = c_BAUD_DIV >> 1;
    localparam logic [31:0] c_TIMEOUT_CYC = 32'(TIMEOUT_MS * (CLK_FREQ / 1000));

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} byte_state_t;
    typedef enum logic [1:0] {P_HDR, P_ADDR, P_DATA, P_CKSUM} parse_state_t;

    logic         r_sync1, r_sync2, r_rxd_prev;
    byte_state_t  r_bstate, w_bstate_next;
    logic [15:0]  r_baud_cnt, w_baud_cnt_next;
    logic [2:0]   r_bit_idx, w_bit_idx_next;
    logic [7:0]   r_shift, w_shift_next;
    logic         r_brk, w_brk_next;
    logic         w_rx_done, w_frame_bad;

    logic [7:0]   r_rx_data;
    logic         r_rx_valid, r_frame_err;

    parse_state_t r_pstate, w_pstate_next;
    logic [1:0]   r_byte_idx, w_byte_idx_next;
    logic [7:0]   r_addr_sh, w_addr_sh_next;
    logic [31:0]  r_data_sh, w_data_sh_next;
    logic [7:0]   r_cksum, w_cksum_next;
    logic [31:0]  r_gap, w_gap_next;
    logic         w_cmd_fire, w_cmd_abort;

    logic [7:0]   r_cmd_addr;
    logic [31:0]  r_cmd_data;
    logic         r_cmd_valid, r_cmd_err;

    // ---------------- byte receiver ----------------
    always_comb begin
        w_bstate_next   = r_bstate;
        w_baud_cnt_next = r_baud_cnt + 16'd1;
        w_bit_idx_next  = r_bit_idx;
        w_shift_next    = r_shift;
        w_brk_next      = r_brk;
        w_rx_done       = 1'b0;
        w_frame_bad     = 1'b0;
        case (r_bstate)
            S_IDLE: begin
                w_baud_cnt_next = 16'd0;
                w_brk_next      = 1'b0;
                if (r_rxd_prev && !r_sync2)
                    w_bstate_next = S_START;
            end
            S_START: begin
                if (r_baud_cnt == c_HALF_DIV - 16'd1) begin
                    w_baud_cnt_next = 16'd0;
                    w_bit_idx_next  = 3'd0;
                    w_bstate_next   = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_baud_cnt == c_BAUD_DIV - 16'd1) begin
                    w_baud_cnt_next = 16'd0;
                    w_shift_next    = {r_sync2, r_shift[7:1]};
                    w_bit_idx_next  = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7)
                        w_bstate_next = S_STOP;
                end
            end
            S_STOP: begin
                // After a bad stop bit, hold here until the line returns high
                if (r_brk) begin
                    w_baud_cnt_next = 16'd0;
                    if (r_sync2)
                        w_bstate_next = S_IDLE;
                end else if (r_baud_cnt == c_BAUD_DIV - 16'd1) begin
                    w_baud_cnt_next = 16'd0;
                    if (r_sync2) begin
                        w_rx_done     = 1'b1;
                        w_bstate_next = S_IDLE;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_brk_next  = 1'b1;
                    end
                end
            end
            default: w_bstate_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rxd_prev  <= 1'b1;
            r_bstate    <= S_IDLE;
            r_baud_cnt  <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_brk       <= 1'b0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= uart_rxd;
            r_sync2     <= r_sync1;
            r_rxd_prev  <= r_sync2;
            r_bstate    <= w_bstate_next;
            r_baud_cnt  <= w_baud_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_brk       <= w_brk_next;
            r_rx_valid  <= w_rx_done;
            r_frame_err <= w_frame_bad;
            if (w_rx_done)
                r_rx_data <= r_shift;
        end
    end

    // ---------------- command parser ----------------
    always_comb begin
        w_pstate_next   = r_pstate;
        w_byte_idx_next = r_byte_idx;
        w_addr_sh_next  = r_addr_sh;
        w_data_sh_next  = r_data_sh;
        w_cksum_next    = r_cksum;
        w_gap_next      = (r_pstate == P_HDR) ? 32'd0 : r_gap + 32'd1;
        w_cmd_fire      = 1'b0;
        w_cmd_abort     = 1'b0;
        if (r_rx_valid) begin
            w_gap_next = 32'd0;
            case (r_pstate)
                P_HDR: begin
                    if (r_rx_data == 8'h55) begin
                        w_pstate_next = P_ADDR;
                        w_cksum_next  = 8'd0;
                    end
                end
                P_ADDR: begin
                    w_addr_sh_next  = r_rx_data;
                    w_cksum_next    = r_cksum ^ r_rx_data;
                    w_byte_idx_next = 2'd0;
                    w_pstate_next   = P_DATA;
                end
                P_DATA: begin
                    w_data_sh_next  = {r_data_sh[23:0], r_rx_data};
                    w_cksum_next    = r_cksum ^ r_rx_data;
                    w_byte_idx_next = r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
`ifdef UART_RX_CKSUM_EN
                        w_pstate_next = P_CKSUM;
`else
                        w_pstate_next = P_HDR;
                        w_cmd_fire    = 1'b1;
`endif
                    end
                end
`ifdef UART_RX_CKSUM_EN
                P_CKSUM: begin
                    w_pstate_next = P_HDR;
                    if (r_rx_data == r_cksum)
                        w_cmd_fire  = 1'b1;
                    else
                        w_cmd_abort = 1'b1;
                end
`endif
                default: w_pstate_next = P_HDR;
            endcase
        end else if (r_frame_err && (r_pstate != P_HDR)) begin
            w_pstate_next = P_HDR;
            w_cmd_abort   = 1'b1;
            w_gap_next    = 32'd0;
        end else if ((r_pstate != P_HDR) && (r_gap == c_TIMEOUT_CYC - 32'd1)) begin
            w_pstate_next = P_HDR;
            w_cmd_abort   = 1'b1;
            w_gap_next    = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pstate    <= P_HDR;
            r_byte_idx  <= 2'd0;
            r_addr_sh   <= 8'd0;
            r_data_sh   <= 32'd0;
            r_cksum     <= 8'd0;
            r_gap       <= 32'd0;
            r_cmd_addr  <= 8'd0;
            r_cmd_data  <= 32'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_pstate    <= w_pstate_next;
            r_byte_idx  <= w_byte_idx_next;
            r_addr_sh   <= w_addr_sh_next;
            r_data_sh   <= w_data_sh_next;
            r_cksum     <= w_cksum_next;
            r_gap       <= w_gap_next;
            r_cmd_valid <= w_cmd_fire;
            r_cmd_err   <= w_cmd_abort;
            // Without a checksum the final data byte is still in flight here
            if (w_cmd_fire) begin
                r_cmd_addr <= r_addr_sh;
                r_cmd_data <= w_data_sh_next;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_data  = r_cmd_data;
    assign cmd_valid = r_cmd_valid;
    assign cmd_err   = r_cmd_err;

endmodule
`default_nettype wire
